// File: rtl/rbs_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor:
// FSM state encoding and the counter-width helper.
package rbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/rbs_subtractor.sv
// Bit-serial ripple-borrow subtractor: DIFF = A - B - Bin over WIDTH cycles,
// LSB first, with a START/DONE handshake. One full_subtractor cell is reused
// every cycle on the operand LSBs and the running borrow.
// Optional feature: define SUB_OVERFLOW_EN to add the signed-overflow output OVF.
module rbs_subtractor
  import rbs_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             OVF
`endif
);

  localparam int             CW   = clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_d;
  logic bit_bout;

  // Shared cell: operates on the current operand LSBs and the borrow flop.
  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // Next-state and datapath: capture on accepted START, shift one bit per RUN cycle.
  always_comb begin
    // NOTE: every target gets a hold default first so no path can infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (START) begin
          state_d = RUN;
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          cnt_d   = '0;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      RUN: begin
        // Result bits enter at the MSB and move right, so bit i ends at DIFF[i].
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = bit_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = FIN;
          cnt_d    = '0;
          borrow_d = bit_bout;
`ifdef SUB_OVERFLOW_EN
          // After WIDTH-1 shifts the operand LSBs hold the original MSBs,
          // and bit_d is the final result MSB.
          ovf_d    = (a_q[0] ^ b_q[0]) & (bit_d ^ a_q[0]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign BUSY   = (state_q == RUN);
  assign DONE   = (state_q == FIN);
  assign DIFF   = diff_q;
  assign BORROW = borrow_q;
`ifdef SUB_OVERFLOW_EN
  assign OVF    = ovf_q;
`endif

endmodule

// File: tb/tb_rbs_subtractor.sv
// Directed testbench for rbs_subtractor (WIDTH=4). Define SUB_OVERFLOW_EN to
// also exercise the OVF output.
module tb_rbs_subtractor;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] DIFF;
  logic             BORROW;
`ifdef SUB_OVERFLOW_EN
  logic             OVF;
`endif

  int total = 0;
  int bad   = 0;

  rbs_subtractor #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .A      (A),
    .B      (B),
    .Bin    (Bin),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .DIFF   (DIFF),
    .BORROW (BORROW)
`ifdef SUB_OVERFLOW_EN
    ,
    .OVF    (OVF)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One operation from START; observes BUSY/DONE for WIDTH+3 cycles after the
  // accepting edge. With disturb set, START is pulsed again 2 cycles into RUN.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH-1:0] exp_diff, input logic exp_borrow,
                        input bit disturb);
    int busy_n;
    int done_n;
    int done_at;
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    @(negedge CLK);
    START = 1'b1; A = a; B = b; Bin = bin;
    @(negedge CLK);
    START = 1'b0;
    for (int n = 1; n <= WIDTH + 3; n++) begin
      if (n > 1) @(negedge CLK);
      busy_n += int'(BUSY);
      if (DONE) begin
        done_n++;
        done_at = n;
        check({tag, ".diff"}, 32'(DIFF), 32'(exp_diff));
        check({tag, ".borrow"}, 32'(BORROW), 32'(exp_borrow));
      end
      if (disturb && n == 2) begin START = 1'b1; A = 4'd9; B = 4'd1; Bin = 1'b0; end
      if (disturb && n == 3) START = 1'b0;
    end
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(WIDTH));
    check({tag, ".done_count"}, 32'(done_n), 32'd1);
    check({tag, ".done_at"}, 32'(done_at), 32'(WIDTH + 1));
    check({tag, ".diff_hold"}, 32'(DIFF), 32'(exp_diff));
    check({tag, ".borrow_hold"}, 32'(BORROW), 32'(exp_borrow));
  endtask

  initial begin
    int done_n;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst.busy", 32'(BUSY), 32'd0);
    check("rst.done", 32'(DONE), 32'd0);
    check("rst.diff", 32'(DIFF), 32'd0);
    check("rst.borrow", 32'(BORROW), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("rst.ovf", 32'(OVF), 32'd0);
`endif
    RST = 1'b0;

    run_op("5-3",     4'd5,  4'd3,  1'b0, 4'd2,  1'b0, 1'b0);
    run_op("3-5",     4'd3,  4'd5,  1'b0, 4'd14, 1'b1, 1'b0);
    run_op("0-0-1",   4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0);
    run_op("13-13-1", 4'd13, 4'd13, 1'b1, 4'd15, 1'b1, 1'b0);
    run_op("15-0",    4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0);
    run_op("0-15-1",  4'd0,  4'd15, 1'b1, 4'd0,  1'b1, 1'b0);
    run_op("ignore",  4'd12, 4'd5,  1'b0, 4'd7,  1'b0, 1'b1);

    // Back-to-back: START held high, second operands presented while DONE is up.
    done_n = 0;
    @(negedge CLK);
    START = 1'b1; A = 4'd6; B = 4'd2; Bin = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      if (DONE) done_n++;
      if (n == WIDTH + 1) begin
        check("b2b.done1", 32'(DONE), 32'd1);
        check("b2b.diff1", 32'(DIFF), 32'd4);
        check("b2b.borrow1", 32'(BORROW), 32'd0);
        A = 4'd2; B = 4'd6;
      end
      if (n == WIDTH + 2) START = 1'b0;
      if (n == 2 * WIDTH + 2) begin
        check("b2b.done2", 32'(DONE), 32'd1);
        check("b2b.diff2", 32'(DIFF), 32'd12);
        check("b2b.borrow2", 32'(BORROW), 32'd1);
      end
    end
    check("b2b.done_count", 32'(done_n), 32'd2);

    // Asynchronous abort during the 2nd RUN cycle.
    @(negedge CLK);
    START = 1'b1; A = 4'd10; B = 4'd3; Bin = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort.busy", 32'(BUSY), 32'd0);
    check("abort.done", 32'(DONE), 32'd0);
    check("abort.diff", 32'(DIFF), 32'd0);
    check("abort.borrow", 32'(BORROW), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("abort.ovf", 32'(OVF), 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    done_n = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge CLK);
      if (DONE) done_n++;
    end
    check("abort.no_done", 32'(done_n), 32'd0);
    run_op("after_abort", 4'd10, 4'd3, 1'b1, 4'd6, 1'b0, 1'b0);

`ifdef SUB_OVERFLOW_EN
    run_op("8-1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
    check("8-1.ovf", 32'(OVF), 32'd1);
    run_op("7-1", 4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0);
    check("7-1.ovf", 32'(OVF), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
